// File: rtl/reg32_write_arbiter.sv
// Round-robin write arbiter that shares one external CE-gated register among NREQ writers.
// Each transaction uses one IDLE->GRANT cycle: the grant edge latches D and raises CE for exactly one cycle.
module reg32_write_arbiter #(
   parameter int NREQ = 2,
   parameter int DW   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*DW-1:0]  wdata,
   output logic [NREQ-1:0]     gnt,
   output logic                reg_ce,
   output logic [DW-1:0]       reg_d,
   output logic                busy,
   output logic [15:0]         wr_count
);

   localparam int PW = $clog2(NREQ);
   localparam int SW = PW + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q,    state_d;
   logic [PW-1:0]     rr_ptr_q,   rr_ptr_d;
   logic [PW-1:0]     win_q,      win_d;
   logic [NREQ-1:0]   gnt_q,      gnt_d;
   logic              reg_ce_q,   reg_ce_d;
   logic [DW-1:0]     reg_d_q,    reg_d_d;
   logic [15:0]       wr_count_q, wr_count_d;

   logic              pick_vld;
   logic [PW-1:0]     pick_idx;
   logic [DW-1:0]     pick_data;
   logic [SW-1:0]     cand_sum;
   logic [PW-1:0]     cand;

   // Scan from rr_ptr upward, wrapping at NREQ; the first live request wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand_sum = '0;
      cand     = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + SW'(k);
         if (cand_sum >= SW'(NREQ)) begin
            cand_sum = cand_sum - SW'(NREQ);
         end
         cand = cand_sum[PW-1:0];
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      pick_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == PW'(i)) begin
            pick_data = wdata[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      win_d      = win_q;
      gnt_d      = '0;
      reg_ce_d   = 1'b0;
      reg_d_d    = reg_d_q;
      wr_count_d = wr_count_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               win_d    = pick_idx;
               gnt_d    = NREQ'(1) << pick_idx;
               reg_ce_d = 1'b1;
               reg_d_d  = pick_data;
               state_d  = GRANT;
            end
         end
         GRANT: begin
            // Requests are ignored here; the winner drops to lowest priority.
            wr_count_d = wr_count_q + 16'd1;
            if (win_q == PW'(NREQ - 1)) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = win_q + PW'(1);
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         win_q      <= '0;
         gnt_q      <= '0;
         reg_ce_q   <= 1'b0;
         reg_d_q    <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         win_q      <= win_d;
         gnt_q      <= gnt_d;
         reg_ce_q   <= reg_ce_d;
         reg_d_q    <= reg_d_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign gnt      = gnt_q;
   assign reg_ce   = reg_ce_q;
   assign reg_d    = reg_d_q;
   assign busy     = (state_q == GRANT);
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg32_write_arbiter.sv
// Directed bench for reg32_write_arbiter: stimulus queues expected grants, a negedge monitor checks them.
module tb_reg32_write_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req = '0;
   logic [63:0] wdata = '0;
   logic [1:0]  gnt;
   logic        reg_ce;
   logic [31:0] reg_d;
   logic        busy;
   logic [15:0] wr_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [1:0]  gnt;
      logic [31:0] data;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   reg32_write_arbiter #(.NREQ(2), .DW(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wdata    (wdata),
      .gnt      (gnt),
      .reg_ce   (reg_ce),
      .reg_d    (reg_d),
      .busy     (busy),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] g, input logic [31:0] d, input logic [15:0] c);
      exp_t e;
      e.gnt  = g;
      e.data = d;
      e.cnt  = c;
      exp_q.push_back(e);
   endtask

   // Drop each request in its grant cycle; optionally scramble wdata0 right after it was latched.
   task automatic run(input int maxcyc, input bit mod_data);
      int n;
      n = 0;
      while (req != 2'b00) begin
         @(posedge clk); #2;
         if (mod_data && gnt[0]) wdata[31:0] = 32'h1234_5678;
         req = req & ~gnt;
         n++;
         if (n > maxcyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout: req=%b still pending after %0d cycles", req, maxcyc);
            req = 2'b00;
         end
      end
      @(posedge clk); #2;
   endtask

   always @(negedge clk) begin
      if (reg_ce) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_grant: gnt=%b reg_d=0x%08h", gnt, reg_d);
         end else begin
            mon_e = exp_q.pop_front();
            chk("grant_gnt",  {30'd0, gnt}, {30'd0, mon_e.gnt});
            chk("grant_data", reg_d, mon_e.data);
            chk("grant_cnt",  {16'd0, wr_count}, {16'd0, mon_e.cnt});
            chk("grant_busy", {31'd0, busy}, 32'd1);
         end
      end else begin
         chk("idle_gnt_busy", {29'd0, gnt, busy}, 32'd0);
      end
   end

   initial begin
      #1 rst = 1'b1;
      @(posedge clk); #2;
      chk("rst_gnt",    {30'd0, gnt}, 32'd0);
      chk("rst_ce",     {31'd0, reg_ce}, 32'd0);
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_cnt",    {16'd0, wr_count}, 32'd0);
      chk("rst_reg_d",  reg_d, 32'd0);
      rst = 1'b0;
      @(posedge clk); #2;

      // single write
      push(2'b01, 32'hDEAD_BEEF, 16'd0);
      wdata[31:0] = 32'hDEAD_BEEF;
      req = 2'b01;
      run(20, 1'b0);
      chk("single_ce_after", {31'd0, reg_ce}, 32'd0);
      chk("single_cnt",      {16'd0, wr_count}, 32'd1);
      chk("single_hold_d",   reg_d, 32'hDEAD_BEEF);

      // fairness: requester 0 was just served, so 1 wins
      push(2'b10, 32'h2222_2222, 16'd1);
      push(2'b01, 32'h1111_1111, 16'd2);
      wdata = {32'h2222_2222, 32'h1111_1111};
      req = 2'b11;
      run(20, 1'b0);
      chk("fair_cnt", {16'd0, wr_count}, 32'd3);

      // data latched at grant edge
      push(2'b01, 32'hCAFE_F00D, 16'd3);
      wdata[31:0] = 32'hCAFE_F00D;
      req = 2'b01;
      run(20, 1'b1);
      chk("latch_reg_d", reg_d, 32'hCAFE_F00D);
      chk("latch_cnt",   {16'd0, wr_count}, 32'd4);

      // request raised during GRANT and withdrawn in IDLE is never granted
      push(2'b01, 32'h0BAD_C0DE, 16'd4);
      wdata[31:0] = 32'h0BAD_C0DE;
      req = 2'b01;
      @(posedge clk); #2;
      wdata[63:32] = 32'h5555_5555;
      req = 2'b10;
      @(posedge clk); #2;
      req = 2'b00;
      repeat (4) @(posedge clk);
      #2;
      chk("withdraw_cnt",   {16'd0, wr_count}, 32'd5);
      chk("withdraw_reg_d", reg_d, 32'h0BAD_C0DE);

      // async reset in the middle of a grant cycle
      wdata[63:32] = 32'h7777_7777;
      req = 2'b10;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("midrst_gnt",   {30'd0, gnt}, 32'd0);
      chk("midrst_ce",    {31'd0, reg_ce}, 32'd0);
      chk("midrst_busy",  {31'd0, busy}, 32'd0);
      chk("midrst_cnt",   {16'd0, wr_count}, 32'd0);
      chk("midrst_reg_d", reg_d, 32'd0);

      // contention from reset: alternating grants, pointer wraps 1->0
      wdata = {32'hBBBB_0002, 32'hAAAA_0001};
      req = 2'b11;
      push(2'b01, 32'hAAAA_0001, 16'd0);
      push(2'b10, 32'hBBBB_0002, 16'd1);
      push(2'b01, 32'hAAAA_0001, 16'd2);
      push(2'b10, 32'hBBBB_0002, 16'd3);
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      req = 2'b00;
      repeat (3) @(posedge clk);
      #2;
      chk("contend_cnt", {16'd0, wr_count}, 32'd4);

      // counter wrap: preload near the top instead of 65k writes
      force dut.wr_count_q = 16'hFFFE;
      @(posedge clk); #2;
      release dut.wr_count_q;
      push(2'b01, 32'hF00D_F00D, 16'hFFFE);
      wdata[31:0] = 32'hF00D_F00D;
      req = 2'b01;
      run(20, 1'b0);
      chk("wrap_cnt_top", {16'd0, wr_count}, 32'h0000_FFFF);
      push(2'b01, 32'hFEED_FACE, 16'hFFFF);
      wdata[31:0] = 32'hFEED_FACE;
      req = 2'b01;
      run(20, 1'b0);
      chk("wrap_cnt_zero", {16'd0, wr_count}, 32'd0);

      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
